// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm/sequencing controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: set-FSM and ring-FSM state enums, time-field limits, alarm reset
// value, auto-repeat delay, and wrap-around increment helpers for the fields.
package alarm_pkg;

    typedef enum logic [2:0] {
        SET_RUN     = 3'd0,
        SET_HOUR    = 3'd1,
        SET_MIN     = 3'd2,
        SET_AL_HOUR = 3'd3,
        SET_AL_MIN  = 3'd4
    } set_state_t;

    typedef enum logic [1:0] {
        RING_IDLE    = 2'd0,
        RING_RINGING = 2'd1,
        RING_SNOOZED = 2'd2
    } ring_state_t;

    localparam int HOUR_MAX           = 23;
    localparam int MINUTE_MAX         = 59;
    localparam int ALARM_RESET_HOUR   = 6;
    localparam int ALARM_RESET_MINUTE = 0;
    localparam int REPEAT_DELAY_QTR   = 4;

    // Hour field increment, 23 wraps to 0.
    function automatic logic [4:0] hour_wrap_inc(input logic [4:0] h);
        return (h == 5'(HOUR_MAX)) ? 5'd0 : h + 5'd1;
    endfunction

    // Minute field increment, 59 wraps to 0 with no carry into the hour.
    function automatic logic [5:0] minute_wrap_inc(input logic [5:0] m);
        return (m == 6'(MINUTE_MAX)) ? 6'd0 : m + 6'd1;
    endfunction

endpackage

// File: rtl/button_repeat.sv
// Increment-event generator: rising-edge detect plus hold-to-auto-repeat.
// Latency: combinational event in the cycle the edge/qualifying tick is seen.
// Backpressure: none; events are single-cycle and must be consumed immediately.
//
// Ports:
//   clock, reset (async, active-low)
//   btn       debounced button level, high = pressed
//   tick_qtr  one-cycle quarter-second pulse
//   inc_event one event per press edge, then one per tick_qtr once the button
//             has been held for REPEAT_DELAY_QTR quarter-seconds
module button_repeat
    import alarm_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic btn,
    input  logic tick_qtr,
    output logic inc_event
);

    localparam int HOLD_W = $clog2(REPEAT_DELAY_QTR + 1);

    logic              btn_prev_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              hold_full;

    always_comb begin
        hold_full  = (hold_cnt_q == HOLD_W'(REPEAT_DELAY_QTR));
        hold_cnt_d = hold_cnt_q;
        if (!btn) begin
            hold_cnt_d = '0;
        end else if (tick_qtr && !hold_full) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        // The hold counter saturates; every tick after saturation repeats.
        inc_event = (btn & ~btn_prev_q) | (btn & tick_qtr & hold_full);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_prev_q <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            btn_prev_q <= btn;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Set/edit sequencer and alarm ring/snooze controller for the 24-hour clock.
// Latency: button edge or alarm match in cycle n -> registered outputs in n+1.
// Backpressure: none; command pulses are one cycle, consumer must take them.
//
// Ports:
//   clock, reset (async, active-low)
//   tick_1s, tick_qtr                     timing pulses
//   btn_mode, btn_inc, btn_stop           debounced button levels
//   alarm_armed                           alarm enable switch
//   time_hour/minute/second               running time from the counter
//   count_enable, inc_hour, inc_minute,
//   clear_second                          commands to the time counter
//   alarm_hour, alarm_minute, show_alarm,
//   blink_hour, blink_minute              display controls
//   buzzer, mode                          ring output and set-FSM state
// Build option: define ALARM_SNOOZE_EN to make btn_stop snooze instead of stop.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       tick_qtr,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_stop,
    input  logic       alarm_armed,
    input  logic [4:0] time_hour,
    input  logic [5:0] time_minute,
    input  logic [5:0] time_second,
    output logic       count_enable,
    output logic       inc_hour,
    output logic       inc_minute,
    output logic       clear_second,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic       show_alarm,
    output logic       blink_hour,
    output logic       blink_minute,
    output logic       buzzer,
    output logic [2:0] mode
);

    localparam int RING_W = $clog2(RING_SECONDS + 1);

    if (RING_SECONDS < 1 || RING_SECONDS > 255) begin : g_bad_ring
        $error("RING_SECONDS must be 1..255");
    end
    if (SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 15) begin : g_bad_snooze
        $error("SNOOZE_MINUTES must be 1..15");
    end

    // ---------------------------------------------------------------- state
    set_state_t        set_q, set_d;
    ring_state_t       ring_q, ring_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic              fired_q, fired_d;
    logic [4:0]        alarm_hour_q, alarm_hour_d;
    logic [5:0]        alarm_minute_q, alarm_minute_d;
    logic              mode_prev_q, stop_prev_q;

    logic inc_hour_q, inc_hour_d;
    logic inc_minute_q, inc_minute_d;
    logic clear_second_q, clear_second_d;
    logic count_enable_q, count_enable_d;
    logic show_alarm_q, show_alarm_d;
    logic blink_hour_q, blink_hour_d;
    logic blink_minute_q, blink_minute_d;
    logic buzzer_q, buzzer_d;

`ifdef ALARM_SNOOZE_EN
    localparam int SNOOZE_TICKS = SNOOZE_MINUTES * 60;
    localparam int SNOOZE_W     = $clog2(SNOOZE_TICKS + 1);
    logic [SNOOZE_W-1:0] snooze_cnt_q, snooze_cnt_d;
`endif

    logic mode_edge, stop_edge, inc_event, inc_ok, alarm_match;

    button_repeat u_inc_repeat (
        .clock     (clock),
        .reset     (reset),
        .btn       (btn_inc),
        .tick_qtr  (tick_qtr),
        .inc_event (inc_event)
    );

    // ------------------------------------------------------------- set FSM
    always_comb begin
        mode_edge = btn_mode & ~mode_prev_q;
        // A mode change in the same cycle swallows the increment so a field
        // is never bumped while the FSM is leaving it.
        inc_ok    = inc_event & ~mode_edge;

        set_d = set_q;
        if (mode_edge) begin
            case (set_q)
                SET_RUN:     set_d = SET_HOUR;
                SET_HOUR:    set_d = SET_MIN;
                SET_MIN:     set_d = SET_AL_HOUR;
                SET_AL_HOUR: set_d = SET_AL_MIN;
                default:     set_d = SET_RUN;
            endcase
        end

        inc_hour_d     = inc_ok && (set_q == SET_HOUR);
        inc_minute_d   = inc_ok && (set_q == SET_MIN);
        clear_second_d = mode_edge && (set_q == SET_MIN);

        alarm_hour_d   = alarm_hour_q;
        alarm_minute_d = alarm_minute_q;
        if (inc_ok && (set_q == SET_AL_HOUR)) begin
            alarm_hour_d = hour_wrap_inc(alarm_hour_q);
        end
        if (inc_ok && (set_q == SET_AL_MIN)) begin
            alarm_minute_d = minute_wrap_inc(alarm_minute_q);
        end

        // Level outputs follow the next state so they stay aligned with mode.
        count_enable_d = !((set_d == SET_HOUR) || (set_d == SET_MIN));
        show_alarm_d   = (set_d == SET_AL_HOUR) || (set_d == SET_AL_MIN);
        blink_hour_d   = (set_d == SET_HOUR) || (set_d == SET_AL_HOUR);
        blink_minute_d = (set_d == SET_MIN) || (set_d == SET_AL_MIN);
    end

    // ------------------------------------------------------------ ring FSM
    always_comb begin
        stop_edge   = btn_stop & ~stop_prev_q;
        alarm_match = alarm_armed && !fired_q &&
                      (time_hour == alarm_hour_q) &&
                      (time_minute == alarm_minute_q) &&
                      (time_second == 6'd0);

        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        fired_d    = fired_q;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_d = snooze_cnt_q;
`endif

        // Re-arming the one-shot once the alarm minute has passed.
        if (time_minute != alarm_minute_q) begin
            fired_d = 1'b0;
        end

        if (!alarm_armed) begin
            ring_d     = RING_IDLE;
            ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_d = '0;
`endif
        end else begin
            case (ring_q)
                RING_IDLE: begin
                    if (alarm_match) begin
                        ring_d     = RING_RINGING;
                        ring_cnt_d = RING_W'(RING_SECONDS);
                        fired_d    = 1'b1;
                    end
                end
                RING_RINGING: begin
                    // Stop is checked first so it wins over a coincident timeout.
                    if (stop_edge) begin
`ifdef ALARM_SNOOZE_EN
                        ring_d       = RING_SNOOZED;
                        snooze_cnt_d = SNOOZE_W'(SNOOZE_TICKS);
`else
                        ring_d       = RING_IDLE;
`endif
                        ring_cnt_d = '0;
                    end else if (tick_1s) begin
                        if (ring_cnt_q <= RING_W'(1)) begin
                            ring_d     = RING_IDLE;
                            ring_cnt_d = '0;
                        end else begin
                            ring_cnt_d = ring_cnt_q - RING_W'(1);
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                RING_SNOOZED: begin
                    if (tick_1s) begin
                        if (snooze_cnt_q <= SNOOZE_W'(1)) begin
                            ring_d       = RING_RINGING;
                            ring_cnt_d   = RING_W'(RING_SECONDS);
                            snooze_cnt_d = '0;
                            fired_d      = 1'b1;
                        end else begin
                            snooze_cnt_d = snooze_cnt_q - SNOOZE_W'(1);
                        end
                    end
                end
`endif
                default: ring_d = RING_IDLE;
            endcase
        end

        buzzer_d = (ring_d == RING_RINGING);
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            set_q          <= SET_RUN;
            ring_q         <= RING_IDLE;
            ring_cnt_q     <= '0;
            fired_q        <= 1'b0;
            alarm_hour_q   <= 5'(ALARM_RESET_HOUR);
            alarm_minute_q <= 6'(ALARM_RESET_MINUTE);
            mode_prev_q    <= 1'b0;
            stop_prev_q    <= 1'b0;
            inc_hour_q     <= 1'b0;
            inc_minute_q   <= 1'b0;
            clear_second_q <= 1'b0;
            count_enable_q <= 1'b1;
            show_alarm_q   <= 1'b0;
            blink_hour_q   <= 1'b0;
            blink_minute_q <= 1'b0;
            buzzer_q       <= 1'b0;
        end else begin
            set_q          <= set_d;
            ring_q         <= ring_d;
            ring_cnt_q     <= ring_cnt_d;
            fired_q        <= fired_d;
            alarm_hour_q   <= alarm_hour_d;
            alarm_minute_q <= alarm_minute_d;
            mode_prev_q    <= btn_mode;
            stop_prev_q    <= btn_stop;
            inc_hour_q     <= inc_hour_d;
            inc_minute_q   <= inc_minute_d;
            clear_second_q <= clear_second_d;
            count_enable_q <= count_enable_d;
            show_alarm_q   <= show_alarm_d;
            blink_hour_q   <= blink_hour_d;
            blink_minute_q <= blink_minute_d;
            buzzer_q       <= buzzer_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snooze_cnt_q <= '0;
        end else begin
            snooze_cnt_q <= snooze_cnt_d;
        end
    end
`endif

    assign count_enable = count_enable_q;
    assign inc_hour     = inc_hour_q;
    assign inc_minute   = inc_minute_q;
    assign clear_second = clear_second_q;
    assign alarm_hour   = alarm_hour_q;
    assign alarm_minute = alarm_minute_q;
    assign show_alarm   = show_alarm_q;
    assign blink_hour   = blink_hour_q;
    assign blink_minute = blink_minute_q;
    assign buzzer       = buzzer_q;
    assign mode         = set_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller.
// Command pulses are predicted into a scoreboard queue and retired by a monitor.
// Build with or without ALARM_SNOOZE_EN; snooze expectations follow the macro.
module tb_alarm_controller;

`ifdef ALARM_SNOOZE_EN
    localparam int SNOOZE_ON = 1;
`else
    localparam int SNOOZE_ON = 0;
`endif

    localparam logic [2:0] P_HOUR = 3'b100;
    localparam logic [2:0] P_MIN  = 3'b010;
    localparam logic [2:0] P_CLR  = 3'b001;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1s = 1'b0, tick_qtr = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_stop = 1'b0;
    logic       alarm_armed = 1'b0;
    logic [4:0] time_hour = 5'd0;
    logic [5:0] time_minute = 6'd0, time_second = 6'd0;
    logic       count_enable, inc_hour, inc_minute, clear_second;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_minute;
    logic       show_alarm, blink_hour, blink_minute, buzzer;
    logic [2:0] mode;

    int tests_run = 0;
    int tests_failed = 0;
    logic [2:0] sb_q[$];

    alarm_controller #(.RING_SECONDS(60), .SNOOZE_MINUTES(9)) dut (
        .clock(clock), .reset(reset), .tick_1s(tick_1s), .tick_qtr(tick_qtr),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_stop(btn_stop),
        .alarm_armed(alarm_armed), .time_hour(time_hour),
        .time_minute(time_minute), .time_second(time_second),
        .count_enable(count_enable), .inc_hour(inc_hour),
        .inc_minute(inc_minute), .clear_second(clear_second),
        .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .show_alarm(show_alarm), .blink_hour(blink_hour),
        .blink_minute(blink_minute), .buzzer(buzzer), .mode(mode)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Retire every observed command pulse against the predicted queue.
    always @(negedge clock) begin
        logic [2:0] seen;
        logic [2:0] want;
        seen = {inc_hour, inc_minute, clear_second};
        if (reset && seen != 3'b000) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", int'(seen), 0);
            end else begin
                want = sb_q.pop_front();
                check("pulse", int'(seen), int'(want));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press_mode(input bit with_inc);
        btn_mode = 1'b1;
        btn_inc  = with_inc;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        step();
        btn_inc = 1'b0;
        step();
    endtask

    task automatic tick_s(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1s = 1'b1;
            step();
            tick_1s = 1'b0;
            step();
        end
    endtask

    typedef struct {
        bit         with_inc;
        bit         exp_clr;
        logic [2:0] exp_mode;
        logic       exp_ce;
        logic       exp_show;
        logic       exp_bh;
        logic       exp_bm;
    } mode_vec_t;

    mode_vec_t vec[5];

    initial begin
        // {inc pressed with mode, clear_second expected, mode, ce, show, blink_h, blink_m}
        vec[0] = '{1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[1] = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[2] = '{1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0};
        vec[3] = '{1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1};
        vec[4] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        // ---- reset values
        reset = 1'b0;
        step(); step();
        check("rst_mode", mode, 0);
        check("rst_count_enable", count_enable, 1);
        check("rst_buzzer", buzzer, 0);
        check("rst_alarm_hour", alarm_hour, 6);
        check("rst_alarm_minute", alarm_minute, 0);
        check("rst_pulses", {inc_hour, inc_minute, clear_second}, 0);
        reset = 1'b1;
        step();

        // ---- mode walk; second step also presses inc to show mode wins
        for (int i = 0; i < 5; i++) begin
            if (vec[i].exp_clr) sb_q.push_back(P_CLR);
            press_mode(vec[i].with_inc);
            check("walk_mode", mode, vec[i].exp_mode);
            check("walk_count_enable", count_enable, vec[i].exp_ce);
            check("walk_show_alarm", show_alarm, vec[i].exp_show);
            check("walk_blink", {blink_hour, blink_minute}, {vec[i].exp_bh, vec[i].exp_bm});
        end

        // ---- inc ignored in RUN
        press_inc();
        check("run_inc_ignored", {alarm_hour, alarm_minute}, {5'd6, 6'd0});

        // ---- alarm hour 6 -> 9
        press_mode(0);
        press_mode(0);
        sb_q.push_back(P_CLR);
        press_mode(0);
        for (int i = 0; i < 3; i++) begin
            press_inc();
            check("al_hour_count_enable", count_enable, 1);
        end
        check("alarm_hour_9", alarm_hour, 9);
        check("alarm_minute_0", alarm_minute, 0);

        // ---- alarm minute wrap 59 -> 0, no hour carry
        press_mode(0);
        for (int i = 0; i < 59; i++) press_inc();
        check("alarm_minute_59", alarm_minute, 59);
        press_inc();
        check("alarm_minute_wrap", alarm_minute, 0);
        check("alarm_hour_no_carry", alarm_hour, 9);
        press_mode(0);
        check("back_to_run", mode, 0);

        // ---- time hour increment and held-button auto-repeat in SET_MIN
        press_mode(0);
        sb_q.push_back(P_HOUR);
        press_inc();
        press_mode(0);
        sb_q.push_back(P_MIN);
        btn_inc = 1'b1;
        step(); step();
        for (int k = 1; k <= 8; k++) begin
            if (k > 4) sb_q.push_back(P_MIN);
            tick_qtr = 1'b1;
            step();
            tick_qtr = 1'b0;
            step(); step();
        end
        check("hold_count_enable", count_enable, 0);
        btn_inc = 1'b0;
        step(); step();
        check("hold_pulses_drained", sb_q.size(), 0);
        sb_q.push_back(P_CLR);
        press_mode(0);
        check("clear_second_drained", sb_q.size(), 0);

        // ---- alarm hour wrap 23 -> 0
        for (int i = 0; i < 14; i++) press_inc();
        check("alarm_hour_23", alarm_hour, 23);
        press_inc();
        check("alarm_hour_wrap", alarm_hour, 0);

        // ---- async reset in SET_AL_MIN
        press_mode(0);
        check("in_set_al_min", mode, 4);
        reset = 1'b0;
        #2;
        check("async_rst_mode", mode, 0);
        check("async_rst_alarm", {alarm_hour, alarm_minute}, {5'd6, 6'd0});
        step();
        reset = 1'b1;
        step();

        // ---- alarm fires at 06:00:00
        alarm_armed = 1'b1;
        time_hour = 5'd5; time_minute = 6'd59; time_second = 6'd59;
        step(); step();
        check("pre_match_quiet", buzzer, 0);
        time_hour = 5'd6; time_minute = 6'd0; time_second = 6'd0;
        @(negedge clock);
        check("match_cycle_quiet", buzzer, 0);
        step();
        check("ring_start", buzzer, 1);
        tick_s(59);
        check("ring_59s", buzzer, 1);
        tick_s(1);
        check("ring_timeout", buzzer, 0);
        tick_s(5);
        check("no_refire", buzzer, 0);

        // ---- fired flag clears once the minute moves on
        time_minute = 6'd1;
        step(); step();
        time_minute = 6'd0;
        step();
        check("refire_after_clear", buzzer, 1);

        // ---- stop / snooze
        tick_s(10);
        btn_stop = 1'b1;
        step();
        check("stop_silences", buzzer, 0);
        btn_stop = 1'b0;
        step();
        tick_s(539);
        check("snooze_wait", buzzer, 0);
        tick_s(1);
        check("snooze_rering", buzzer, SNOOZE_ON);

        // ---- stop coincident with the final ring tick: stop wins
        tick_s(59);
        check("rering_59s", buzzer, SNOOZE_ON);
        btn_stop = 1'b1;
        tick_1s = 1'b1;
        step();
        check("stop_tick_silences", buzzer, 0);
        btn_stop = 1'b0;
        tick_1s = 1'b0;
        step();
        tick_s(540);
        check("stop_beats_timeout", buzzer, SNOOZE_ON);

        // ---- disarm while ringing
        alarm_armed = 1'b0;
        step();
        check("disarmed_idle", buzzer, 0);
        time_minute = 6'd1;
        step(); step();
        time_minute = 6'd0;
        alarm_armed = 1'b1;
        step();
        check("rearm_ring", buzzer, 1);
        alarm_armed = 1'b0;
        @(negedge clock);
        check("disarm_same_cycle", buzzer, 1);
        step();
        check("disarm_next_cycle", buzzer, 0);

        step(); step();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
